// File: rtl/ristretto_mem_pkg.sv
// Shared types and defaults for the ristretto memory-side models.
package ristretto_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } dmem_state_t;

   localparam int unsigned DMemDefaultDepth   = 1024;
   localparam int unsigned DMemDefaultLatency = 1;

endpackage

// File: rtl/ristretto_mem_array.sv
// Synchronous single-port byte-strobed RAM, Depth x DataWidth, registered read.
module ristretto_mem_array #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 1024,
   localparam int unsigned IdxW     = $clog2(Depth)
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [IdxW-1:0]        idx_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic [DataWidth-1:0]   rdata_o
);

   logic [DataWidth-1:0] mem_q [Depth];
   logic [DataWidth-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < DataWidth/8; b++) begin
            if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ristretto_dmem_responder.sv
// Data-memory slave for the core: one transaction at a time, writes win over
// reads, completion signalled by a one-cycle valid pulse after Latency cycles.
module ristretto_dmem_responder
   import ristretto_mem_pkg::*;
#(
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          Depth     = DMemDefaultDepth,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter int unsigned          Latency   = DMemDefaultLatency
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   rdata_req_i,
   input  logic [AddrWidth-1:0]   rdata_addr_i,
   input  logic [DataWidth/8-1:0] rdata_strb_i,
   output logic                   rdata_ready_o,
   output logic                   rdata_valid_o,
   output logic [DataWidth-1:0]   rdata_data_o,
   input  logic                   wdata_req_i,
   input  logic [AddrWidth-1:0]   wdata_addr_i,
   input  logic [DataWidth-1:0]   wdata_data_i,
   input  logic [DataWidth/8-1:0] wdata_strb_i,
   output logic                   wdata_ready_o,
   output logic                   wdata_valid_o
);

   localparam int unsigned          IdxW      = $clog2(Depth);
   localparam int unsigned          CntW      = $clog2(Latency + 1);
   localparam logic [CntW-1:0]      CntLoad   = CntW'(Latency - 1);
   localparam logic [AddrWidth-1:0] SpanBytes = AddrWidth'(Depth * 4);

   dmem_state_t          state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 rd_hit_q, rd_hit_d;
   logic [IdxW-1:0]      idx_q, idx_d;

   logic                 wr_acc, rd_acc;
   logic [AddrWidth-1:0] acc_addr, offset;
   logic                 in_range;
   logic [IdxW-1:0]      acc_idx, ram_idx;
   logic                 ram_we;
   logic [DataWidth-1:0] ram_rdata;
   logic                 unused_strb;

   assign wdata_ready_o = (state_q == IDLE);
   assign rdata_ready_o = (state_q == IDLE) & ~wdata_req_i;

   assign wr_acc = wdata_req_i & wdata_ready_o;
   assign rd_acc = rdata_req_i & rdata_ready_o;

   // In IDLE a pending write always owns the decode path, matching its priority.
   assign acc_addr = wdata_req_i ? wdata_addr_i : rdata_addr_i;
   assign offset   = acc_addr - BaseAddr;
   assign in_range = (offset < SpanBytes);
   assign acc_idx  = offset[IdxW+1:2];

   // Hold the index while waiting so the registered RAM output stays on the read word.
   assign ram_idx = (state_q == IDLE) ? acc_idx : idx_q;
   assign ram_we  = wr_acc & in_range;

   ristretto_mem_array #(
      .DataWidth (DataWidth),
      .Depth     (Depth)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .be_i    (wdata_strb_i),
      .idx_i   (ram_idx),
      .wdata_i (wdata_data_i),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_hit_d = rd_hit_q;
      idx_d    = idx_q;
      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               state_d = WR_WAIT;
               cnt_d   = CntLoad;
               idx_d   = acc_idx;
            end else if (rd_acc) begin
               state_d  = RD_WAIT;
               cnt_d    = CntLoad;
               rd_hit_d = in_range;
               idx_d    = acc_idx;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_hit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_hit_q <= rd_hit_d;
      end
   end

   always_ff @(posedge clk_i) begin
      idx_q <= idx_d;
   end

   assign rdata_valid_o = (state_q == RD_WAIT) && (cnt_q == '0);
   assign wdata_valid_o = (state_q == WR_WAIT) && (cnt_q == '0);
   assign rdata_data_o  = (rdata_valid_o && rd_hit_q) ? ram_rdata : '0;

   assign unused_strb = ^rdata_strb_i;

endmodule

// File: tb/tb_ristretto_dmem_responder.sv
// Randomized bench for ristretto_dmem_responder against a word-array reference model.
module tb_ristretto_dmem_responder;

   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rd_req, rd_ready, rd_valid;
   logic [31:0] rd_addr, rd_data;
   logic [3:0]  rd_strb;
   logic        wr_req, wr_ready, wr_valid;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          accept_wait;
   logic [31:0] last_rd;
   logic [31:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   ristretto_dmem_responder #(
      .DataWidth (32),
      .AddrWidth (32),
      .Depth     (DEPTH),
      .BaseAddr  (BASE),
      .Latency   (LAT)
   ) dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .rdata_req_i   (rd_req),
      .rdata_addr_i  (rd_addr),
      .rdata_strb_i  (rd_strb),
      .rdata_ready_o (rd_ready),
      .rdata_valid_o (rd_valid),
      .rdata_data_o  (rd_data),
      .wdata_req_i   (wr_req),
      .wdata_addr_i  (wr_addr),
      .wdata_data_i  (wr_data),
      .wdata_strb_i  (wr_strb),
      .wdata_ready_o (wr_ready),
      .wdata_valid_o (wr_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < DEPTH * 4;
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off / 4);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (in_rng(a)) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[widx(a)][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      return in_rng(a) ? mem_m[widx(a)] : 32'h0;
   endfunction

   // Wait for acceptance of the pending write or read, then follow it to its valid pulse.
   task automatic serve(input bit is_wr);
      int          n;
      bit          acc;
      logic [31:0] exp_d;
      string       t_acc, t_vld, t_quiet;
      n = 0; acc = 0; exp_d = '0;
      if (is_wr) begin t_acc = "wr_accept"; t_vld = "wr_valid"; t_quiet = "rd_valid_quiet"; end
      else       begin t_acc = "rd_accept"; t_vld = "rd_valid"; t_quiet = "wr_valid_quiet"; end
      while (!acc && n < LAT + 4) begin
         @(negedge clk);
         n++;
         acc = is_wr ? wr_ready : rd_ready;
         if (acc && is_wr && rd_req) check("wr_priority_rd_ready", rd_ready, 0);
      end
      accept_wait = n;
      if (!acc) begin
         check(t_acc, 0, 1);
         wr_req = 0; rd_req = 0;
         @(posedge clk); #1;
         return;
      end
      if (is_wr) model_write(wr_addr, wr_data, wr_strb);
      else       exp_d = model_read(rd_addr);
      @(posedge clk); #1;
      if (is_wr) begin wr_req = 0; wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom); end
      else       begin rd_req = 0; rd_addr = $urandom; end
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         check(t_vld, is_wr ? wr_valid : rd_valid, (k == LAT));
         check(t_quiet, is_wr ? rd_valid : wr_valid, 0);
         check("wr_ready_busy", wr_ready, 0);
         check("rd_ready_busy", rd_ready, 0);
         if (!is_wr) check("rd_data", rd_data, (k == LAT) ? exp_d : 32'h0);
         if (!is_wr && k == LAT) last_rd = rd_data;
      end
      @(posedge clk); #1;
   endtask

   task automatic issue(input bit do_w, input bit do_r, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra);
      wr_addr = wa; wr_data = wd; wr_strb = ws;
      rd_addr = ra; rd_strb = 4'($urandom);
      wr_req = do_w; rd_req = do_r;
      if (do_w) serve(1'b1);
      if (do_r) serve(1'b0);
   endtask

   task automatic reset_mid(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
      int n;
      bit acc;
      n = 0; acc = 0;
      wr_addr = a; wr_data = d; wr_strb = 4'hF; rd_addr = a;
      wr_req = is_wr; rd_req = !is_wr;
      while (!acc && n < LAT + 4) begin
         @(negedge clk);
         n++;
         acc = is_wr ? wr_ready : rd_ready;
      end
      check("rstmid_accept", acc, 1);
      if (acc && is_wr) model_write(a, d, 4'hF);
      @(posedge clk); #1;
      wr_req = 0; rd_req = 0;
      @(negedge clk);
      check("rstmid_pre_valid", rd_valid | wr_valid, 0);
      @(posedge clk); #1;
      rstn = 0;
      repeat (2) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      rstn = 1;
      for (int k = 0; k < LAT + 2; k++) begin
         @(negedge clk);
         check("rstmid_no_valid", {rd_valid, wr_valid}, 2'b00);
         check("rstmid_ready", wr_ready, 1);
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return $urandom;
      return BASE + $urandom_range(0, DEPTH * 4 - 1);
   endfunction

   task automatic sweep();
      for (int i = 0; i < DEPTH; i++) issue(0, 1, 32'h0, 32'h0, 4'h0, BASE + 32'(i * 4));
   endtask

   initial begin
      rstn = 0;
      rd_req = 1; wr_req = 1;
      rd_addr = BASE; wr_addr = BASE; wr_data = 32'h1234_5678; wr_strb = 4'hF; rd_strb = 4'hF;
      last_rd = '0; accept_wait = 0;
      repeat (3) begin
         @(negedge clk);
         check("rst_rd_valid", rd_valid, 0);
         check("rst_wr_valid", wr_valid, 0);
         check("rst_rd_data", rd_data, 32'h0);
      end
      rd_req = 0; wr_req = 0;
      rstn = 1;
      @(posedge clk); #1;
      check("rst_wr_ready", wr_ready, 1);
      check("rst_rd_ready", rd_ready, 1);

      for (int i = 0; i < DEPTH; i++) issue(1, 0, BASE + 32'(i * 4), $urandom, 4'hF, 32'h0);

      issue(1, 0, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0);
      issue(1, 0, BASE + 32'h10, 32'h0000_00AA, 4'b0001, 32'h0);
      issue(0, 1, 32'h0, 32'h0, 4'h0, BASE + 32'h10);
      check("strb_merge", last_rd, 32'hDEAD_BEAA);

      issue(1, 1, BASE + 32'h20, 32'h0000_0055, 4'hF, BASE + 32'h20);
      check("rd_after_wr_wait", accept_wait, 1);
      check("raw_data", last_rd, 32'h0000_0055);

      issue(0, 1, 32'h0, 32'h0, 4'h0, BASE - 32'h4);
      check("oor_read_low", last_rd, 32'h0);
      issue(0, 1, 32'h0, 32'h0, 4'h0, BASE + DEPTH * 4);
      check("oor_read_high", last_rd, 32'h0);
      issue(1, 0, BASE + DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 32'h0);
      issue(1, 0, 32'h0000_2000, 32'hA5A5_A5A5, 4'hF, 32'h0);
      issue(1, 0, 32'h0000_0000, 32'h5A5A_5A5A, 4'hF, 32'h0);
      sweep();

      reset_mid(1'b0, BASE + 32'h40, 32'h0);
      reset_mid(1'b1, BASE + 32'h44, 32'hCAFE_F00D);
      issue(0, 1, 32'h0, 32'h0, 4'h0, BASE + 32'h44);
      check("rstmid_wr_committed", last_rd, 32'hCAFE_F00D);

      for (int i = 0; i < 300; i++) begin
         bit dw, dr;
         logic [31:0] a;
         dw = 1'($urandom);
         dr = 1'($urandom);
         if (!dw && !dr) dr = 1;
         a = rand_addr();
         if ($urandom_range(0, 3) == 0)
            issue(dw, dr, a, $urandom, 4'($urandom), a);
         else
            issue(dw, dr, a, $urandom, 4'($urandom), rand_addr());
      end
      sweep();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
